// File: rtl/evm_pkg.sv
// Shared types and constants for the voter-booth ballot front end.
// The ballot counter width comes from the global WIDTH define; 8 bits is used when nothing else sets it.
`ifndef WIDTH
`define WIDTH 8
`endif

package evm_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_ARMED,
        ST_VOTED_HOLD,
        ST_ERR_HOLD
    } ballot_state_t;

    localparam int CAND_1   = 0;
    localparam int CAND_2   = 1;
    localparam int CAND_3   = 2;
    localparam int NUM_CAND = 3;

    function automatic int timer_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/evm_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one push-button.
// The debounced level follows the input only after DEBOUNCE_CYCLES matching cycles.
module evm_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            // Any cycle where the input agrees with db restarts the qualification window.
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/evm_ballot_unit.sv
// Booth front end: debounces candidate buttons, arms one ballot per release and
// emits one registered vote pulse per valid ballot, with error flags and a saturating tally.
module evm_ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch_on_evm,
    input  logic              ballot_release,
    input  logic              voting_session_done,
    input  logic [2:0]        btn_raw,
    output logic              candidate_ready,
    output logic              vote_candidate_1,
    output logic              vote_candidate_2,
    output logic              vote_candidate_3,
    output logic              multi_press_err,
    output logic              timeout_err,
    output logic [`WIDTH-1:0] ballot_count
);

    localparam int TIMER_W = timer_w(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    ballot_state_t         state, state_nxt;
    logic [NUM_CAND-1:0]   db;
    logic [NUM_CAND-1:0]   vote_q, vote_nxt;
    logic                  multi_nxt, tmo_nxt, count_inc;
    logic                  db_any, db_onehot, db_multi;
    logic [TIMER_W-1:0]    timer;

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
        evm_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .db     (db[i])
        );
    end

    assign db_any    = (db != '0);
    assign db_multi  = ((db & (db - 1'b1)) != '0);
    assign db_onehot = db_any && !db_multi;

    always_comb begin
        state_nxt = state;
        vote_nxt  = '0;
        multi_nxt = 1'b0;
        tmo_nxt   = 1'b0;
        count_inc = 1'b0;
        // Power-off / session close beats everything, including a press maturing this cycle.
        if (!switch_on_evm || voting_session_done) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (ballot_release && !db_any) state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (db_onehot) begin
                        vote_nxt  = db;
                        count_inc = 1'b1;
                        state_nxt = ST_VOTED_HOLD;
                    end else if (db_multi) begin
                        multi_nxt = 1'b1;
                        state_nxt = ST_ERR_HOLD;
                    end else if (timer == TIMER_MAX) begin
                        tmo_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_VOTED_HOLD: begin
                    if (!db_any) state_nxt = ST_IDLE;
                end
                ST_ERR_HOLD: begin
                    if (!db_any) state_nxt = ST_ARMED;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= ST_OFF;
            timer           <= '0;
            vote_q          <= '0;
            multi_press_err <= 1'b0;
            timeout_err     <= 1'b0;
            ballot_count    <= '0;
        end else begin
            state           <= state_nxt;
            vote_q          <= vote_nxt;
            multi_press_err <= multi_nxt;
            timeout_err     <= tmo_nxt;
            // Timer counts only while remaining armed; every fresh entry starts from zero.
            if (state == ST_ARMED && state_nxt == ST_ARMED) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if (count_inc && ballot_count != '1) begin
                ballot_count <= ballot_count + 1'b1;
            end
        end
    end

    assign candidate_ready  = (state == ST_ARMED);
    assign vote_candidate_1 = vote_q[CAND_1];
    assign vote_candidate_2 = vote_q[CAND_2];
    assign vote_candidate_3 = vote_q[CAND_3];

endmodule
